mdu_iter_unit: RTL and testbench

Parametrised iterative multiply/divide unit; the multi-cycle companion to the single-cycle ALU in the in-order execute stage, and the first execution unit with a valid/ready handshake usable by the out-of-order issue logic. It accepts one operation at a time, computes it radix-2 over WIDTH iterations, and holds the result until the consumer takes it. Operand signedness, divide-by-zero and overflow are handled internally to RISC-V M-extension semantics.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_iter.sv | 32 +++
 rtl/mdu_iter_unit.sv | 121 ++++++++++++
 tb/tb_mdu_iter_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_op1(mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_op2(mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step on magnitudes: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout is {high/remainder, low/multiplier-or-quotient}.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
        trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff  = trial - {1'b0, b_i};
        acc_o = '0;
        if (is_div_i) begin
            // No borrow means the shifted remainder covers the divisor: quotient bit 1.
            if (!diff[WIDTH])
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            else
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshake.
// Fixed latency WIDTH+2 from accept to out_valid, regardless of opcode.
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e         state_q;
    mdu_op_e            func_q;
    logic [WIDTH-1:0]   op1_q, op2_q, mag_q, res_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, dbz_q, ovf_q;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   mag1, mag2, quo, rem, res_d;
    logic [2*WIDTH-1:0] prod;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

    assign op1_neg = is_signed_op1(func_q) & op1_q[WIDTH-1];
    assign op2_neg = is_signed_op2(func_q) & op2_q[WIDTH-1];
    assign mag1    = op1_neg ? -op1_q : op1_q;
    assign mag2    = op2_neg ? -op2_q : op2_q;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div(func_q)),
        .acc_i    (acc_q),
        .b_i      (mag_q),
        .acc_o    (acc_d)
    );

    // Sign fix-up and result selection; special cases override the iterated value.
    always_comb begin
        prod  = neg_q ? -acc_q : acc_q;
        quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem   = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_d = '0;
        case (func_q)
            OP_MUL:                       res_d = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res_d = dbz_q ? '1 : (ovf_q ? MIN_VAL : quo);
            default:                      res_d = dbz_q ? op1_q : (ovf_q ? '0 : rem);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            func_q  <= OP_MUL;
            op1_q   <= '0;
            op2_q   <= '0;
            mag_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    func_q  <= mdu_op_e'(in_func);
                    op1_q   <= in_op1;
                    op2_q   <= in_op2;
                    tag_q   <= in_tag;
                    state_q <= ST_PREP;
                end
                ST_PREP: begin
                    acc_q   <= {{WIDTH{1'b0}}, mag1};
                    mag_q   <= mag2;
                    // Remainder takes the dividend's sign; everything else the product sign.
                    neg_q   <= (func_q == OP_REM) ? op1_neg : (op1_neg ^ op2_neg);
                    dbz_q   <= is_div(func_q) && (op2_q == '0);
                    ovf_q   <= (func_q inside {OP_DIV, OP_REM}) && (op1_q == MIN_VAL)
                               && (op2_q == '1);
                    cnt_q   <= CNT_W'(WIDTH - 1);
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    res_q   <= res_d;
                    state_q <= ST_DONE;
                end
                ST_DONE: if (out_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Scoreboard bench for mdu_iter_unit: directed M-extension cases, backpressure,
// flush/reset kill, then randomized traffic against a plain-arithmetic model.
module tb_mdu_iter_unit;

    localparam int W   = 32;
    localparam int TW  = 6;
    localparam int LAT = W + 2;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_func = '0;
    logic [W-1:0]  in_op1 = '0, in_op2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;  // 0 low, 1 high, 2 random
    logic vld_prev = 1'b0;

    mdu_iter_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M semantics with 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb_ = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        logic            ovf = (a == MINV) && (b == '1);
        case (f)
            3'd0: begin p = sa * sb_; return p[W-1:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (ovf) return MINV;
                p = sa / sb_; return p[W-1:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return '0;
                p = sa % sb_; return p[W-1:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: latency on each rising out_valid, result/tag on each handshake.
    always @(negedge clk) begin
        if (out_valid && !vld_prev) begin
            if (sb.size() == 0) chk("unexpected_valid", 64'(out_valid), 64'(0));
            else                chk("latency", 64'(cyc - sb[0].acc), 64'(LAT));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 64'(out_result), 64'(e.res));
            chk("tag", 64'(out_tag), 64'(e.tag));
        end
        vld_prev = out_valid;
    end

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t);
        exp_t e;
        int   k;
        in_func  = f;
        in_op1   = a;
        in_op2   = b;
        in_tag   = t;
        in_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 300) begin
            chk("accept_timeout", 64'(0), 64'(1));
        end else begin
            e.res = model(f, a, b);
            e.tag = t;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk(name, 64'(0), 64'(1));
    endtask

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    op_t dir[11] = '{
        '{3'd1, 32'h8000_0000, 32'h8000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9, 32'd2},
        '{3'd6, 32'hFFFF_FFF9, 32'd2},
        '{3'd5, 32'd100,       32'd7},
        '{3'd7, 32'd100,       32'd7},
        '{3'd4, 32'd1234,      32'd0},
        '{3'd7, 32'd9,         32'd0},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF}
    };

    logic [W-1:0] pool[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};

    function automatic logic [W-1:0] rnd_operand();
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        logic [W-1:0] exp_a;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));

        // MUL 7 x -3, then in_ready must return right after the drain.
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 6'd5);
        wait_valid("mul_valid_timeout");
        @(negedge clk);
        chk("in_ready_after_drain", 64'(in_ready), 64'(1));
        chk("out_valid_after_drain", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        foreach (dir[i]) issue(dir[i].f, dir[i].a, dir[i].b, TW'(i + 10));
        wait_valid("dir_valid_timeout");
        @(posedge clk); #1;

        // Backpressure: result held, second op refused until drain.
        rdy_mode = 0;
        @(posedge clk); #1;
        exp_a = model(3'd4, 32'd100, 32'hFFFF_FFF9);
        issue(3'd4, 32'd100, 32'hFFFF_FFF9, 6'd33);
        wait_valid("bp_valid_timeout");
        in_func  = 3'd0;
        in_op1   = 32'd3;
        in_op2   = 32'd4;
        in_tag   = 6'd34;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_result", 64'(out_result), 64'(exp_a));
            chk("bp_tag", 64'(out_tag), 64'(6'd33));
        end
        rdy_mode = 1;
        issue(3'd0, 32'd3, 32'd4, 6'd34);
        wait_valid("bp2_valid_timeout");
        @(posedge clk); #1;

        // Flush during CALC.
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 6'd40);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        repeat (40) @(posedge clk);
        #1;

        // Reset while holding a result in DONE.
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(3'd5, 32'd77, 32'd5, 6'd41);
        wait_valid("rst_valid_timeout");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rstdone_in_ready", 64'(in_ready), 64'(1));
        chk("rstdone_out_valid", 64'(out_valid), 64'(0));
        chk("rstdone_result", 64'(out_result), 64'(0));
        chk("rstdone_tag", 64'(out_tag), 64'(0));
        rdy_mode = 1;
        repeat (40) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int n = 0; n < 60; n++)
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), TW'($urandom_range(0, 63)));
        rdy_mode = 1;
        for (int k = 0; k < 300 && (sb.size() != 0 || out_valid); k++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
